// File: rtl/ptw_walker_if.sv
// rtl/ptw_walker_if.sv - TLB refill request, PTE memory read port and walk response bundle
interface ptw_walker_if #(
    parameter int PPN_W = 20
);
    logic             io_req_valid;
    logic             io_req_ready;
    logic [26:0]      io_req_bits_addr;
    logic             io_req_bits_fetch;
    logic             io_req_bits_store;
    logic             io_req_bits_pum;
    logic             io_req_bits_mxr;
    logic [1:0]       io_req_bits_prv;
    logic [PPN_W-1:0] io_ptbr_ppn;

    logic             io_mem_req_valid;
    logic             io_mem_req_ready;
    logic [PPN_W+11:0] io_mem_req_addr;
    logic             io_mem_resp_valid;
    logic [63:0]      io_mem_resp_data;

    logic             io_resp_valid;
    logic [PPN_W-1:0] io_resp_pte_ppn;
    logic [7:0]       io_resp_pte_bits;
    logic [1:0]       io_resp_level;
    logic             io_resp_fetch;
    logic             io_resp_store;
    logic             io_resp_pum;
    logic             io_resp_mxr;
    logic [1:0]       io_resp_prv;

    // master: TLB plus memory system; slave: the walker
    modport master (
        output io_req_valid, io_req_bits_addr, io_req_bits_fetch, io_req_bits_store,
               io_req_bits_pum, io_req_bits_mxr, io_req_bits_prv, io_ptbr_ppn,
               io_mem_req_ready, io_mem_resp_valid, io_mem_resp_data,
        input  io_req_ready, io_mem_req_valid, io_mem_req_addr,
               io_resp_valid, io_resp_pte_ppn, io_resp_pte_bits, io_resp_level,
               io_resp_fetch, io_resp_store, io_resp_pum, io_resp_mxr, io_resp_prv
    );

    modport slave (
        input  io_req_valid, io_req_bits_addr, io_req_bits_fetch, io_req_bits_store,
               io_req_bits_pum, io_req_bits_mxr, io_req_bits_prv, io_ptbr_ppn,
               io_mem_req_ready, io_mem_resp_valid, io_mem_resp_data,
        output io_req_ready, io_mem_req_valid, io_mem_req_addr,
               io_resp_valid, io_resp_pte_ppn, io_resp_pte_bits, io_resp_level,
               io_resp_fetch, io_resp_store, io_resp_pum, io_resp_mxr, io_resp_prv
    );
endinterface

// File: rtl/ptw_walker.sv
// rtl/ptw_walker.sv - Sv39 page-table walker, one walk at a time, single outstanding PTE read
module ptw_walker #(
    parameter int PPN_W  = 20,
    parameter int LEVELS = 3
) (
    input  logic        clock,
    input  logic        reset,
    ptw_walker_if.slave io
);
    localparam int VPN_W = 9 * LEVELS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]       level;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
    logic             req_fetch;
    logic             req_store;
    logic             req_pum;
    logic             req_mxr;
    logic [1:0]       req_prv;

    logic [PPN_W-1:0] resp_ppn;
    logic [7:0]       resp_bits;
    logic [1:0]       resp_level;
    logic             resp_fetch;
    logic             resp_store;
    logic             resp_pum;
    logic             resp_mxr;
    logic [1:0]       resp_prv;

    logic [8:0]       vpn_idx;
    logic             pte_v;
    logic             pte_r;
    logic             pte_w;
    logic             pte_x;
    logic             pte_invalid;
    logic             pte_leaf;
    logic             last_level;
    logic             walk_done;
    logic             accept;
    logic             resp_fire;
    logic [PPN_W-1:0] pte_ppn;
    logic             unused_pte_fields;

    assign pte_v   = io.io_mem_resp_data[0];
    assign pte_r   = io.io_mem_resp_data[1];
    assign pte_w   = io.io_mem_resp_data[2];
    assign pte_x   = io.io_mem_resp_data[3];
    assign pte_ppn = io.io_mem_resp_data[10+PPN_W-1:10];
    assign unused_pte_fields = ^{io.io_mem_resp_data[63:10+PPN_W], io.io_mem_resp_data[9:8]};

    // W without R is reserved, so it wins over the leaf test even when X is set
    assign pte_invalid = !pte_v || (pte_w && !pte_r);
    assign pte_leaf    = !pte_invalid && (pte_r || pte_x);
    assign last_level  = (level == 2'(LEVELS - 1));
    assign walk_done   = pte_invalid || pte_leaf || last_level;

    assign accept    = (state == S_IDLE) && io.io_req_valid;
    assign resp_fire = (state == S_WAIT) && io.io_mem_resp_valid;

    // Root level indexes the most significant 9 VPN bits
    always_comb begin
        vpn_idx = '0;
        for (int i = 0; i < LEVELS; i++) begin
            if (level == 2'(i)) begin
                vpn_idx = vpn[9*(LEVELS-1-i) +: 9];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        io.io_req_ready     = 1'b0;
        io.io_mem_req_valid = 1'b0;
        io.io_resp_valid    = 1'b0;
        case (state)
            S_IDLE: begin
                io.io_req_ready = 1'b1;
                if (io.io_req_valid) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                io.io_mem_req_valid = 1'b1;
                if (io.io_mem_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (io.io_mem_resp_valid) begin
                    state_nxt = walk_done ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                io.io_resp_valid = 1'b1;
                state_nxt        = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            level      <= '0;
            vpn        <= '0;
            ppn        <= '0;
            req_fetch  <= 1'b0;
            req_store  <= 1'b0;
            req_pum    <= 1'b0;
            req_mxr    <= 1'b0;
            req_prv    <= '0;
            resp_ppn   <= '0;
            resp_bits  <= '0;
            resp_level <= '0;
            resp_fetch <= 1'b0;
            resp_store <= 1'b0;
            resp_pum   <= 1'b0;
            resp_mxr   <= 1'b0;
            resp_prv   <= '0;
        end else begin
            if (accept) begin
                vpn       <= io.io_req_bits_addr;
                ppn       <= io.io_ptbr_ppn;
                level     <= '0;
                req_fetch <= io.io_req_bits_fetch;
                req_store <= io.io_req_bits_store;
                req_pum   <= io.io_req_bits_pum;
                req_mxr   <= io.io_req_bits_mxr;
                req_prv   <= io.io_req_bits_prv;
            end
            if (resp_fire && !walk_done) begin
                ppn   <= pte_ppn;
                level <= level + 2'd1;
            end
            // Response fields are copied once so they stay put while a new request is captured
            if (resp_fire && walk_done) begin
                resp_ppn   <= pte_ppn;
                resp_bits  <= {io.io_mem_resp_data[7:1], pte_leaf};
                resp_level <= level;
                resp_fetch <= req_fetch;
                resp_store <= req_store;
                resp_pum   <= req_pum;
                resp_mxr   <= req_mxr;
                resp_prv   <= req_prv;
            end
        end
    end

    assign io.io_mem_req_addr  = {ppn, vpn_idx, 3'b000};
    assign io.io_resp_pte_ppn  = resp_ppn;
    assign io.io_resp_pte_bits = resp_bits;
    assign io.io_resp_level    = resp_level;
    assign io.io_resp_fetch    = resp_fetch;
    assign io.io_resp_store    = resp_store;
    assign io.io_resp_pum      = resp_pum;
    assign io.io_resp_mxr      = resp_mxr;
    assign io.io_resp_prv      = resp_prv;
endmodule

// File: tb/tb_ptw_walker.sv
// tb/tb_ptw_walker.sv - randomized walks against a page-table model with a stalling memory responder
module tb_ptw_walker;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [63:0] pmem [logic [31:0]];
    logic [31:0] exp_addr [$];
    logic [19:0] exp_ppn;
    logic [7:0]  exp_bits;
    int          exp_level;

    ptw_walker_if #(.PPN_W(20)) ifc ();

    ptw_walker #(.PPN_W(20), .LEVELS(3)) dut (
        .clock (clock),
        .reset (reset),
        .io    (ifc)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Kinds: 0 pointer, 1 leaf, 2 V=0, 3 W&!R, 4 random, 5 leaf RWXAD
    task automatic model_build(input logic [19:0] ptbr, input logic [26:0] vpn,
                               input int k0, input int k1, input int k2);
        int          kinds [3];
        int          k;
        int          r;
        logic [19:0] cur;
        logic [31:0] a;
        logic [7:0]  f;
        logic [63:0] pte;
        kinds = '{k0, k1, k2};
        exp_addr.delete();
        cur = ptbr;
        for (int lvl = 0; lvl < 3; lvl++) begin
            k = kinds[lvl];
            if (k == 4) begin
                r = int'($urandom_range(0, 9));
                k = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
            end
            a = {cur, vpn[26-9*lvl -: 9], 3'b000};
            f = 8'($urandom);
            case (k)
                0: f[3:0] = 4'b0001;
                1: begin
                    f[0] = 1'b1;
                    if (!f[1] && !f[3]) f[1] = 1'b1;
                    if (f[2]) f[1] = 1'b1;
                end
                2: f[0] = 1'b0;
                3: begin f[0] = 1'b1; f[1] = 1'b0; f[2] = 1'b1; end
                default: f = 8'hCF;
            endcase
            pte = {$urandom(), 2'($urandom), 20'($urandom), 2'($urandom), f};
            pmem[a] = pte;
            exp_addr.push_back(a);
            exp_ppn   = pte[29:10];
            exp_level = lvl;
            if (k == 1 || k == 5) begin
                exp_bits = f;
                break;
            end
            if (k == 2 || k == 3 || lvl == 2) begin
                exp_bits = {f[7:1], 1'b0};
                break;
            end
            cur = pte[29:10];
        end
    endtask

    task automatic run_walk(input logic [19:0] ptbr, input logic [26:0] vpn,
                            input int k0, input int k1, input int k2,
                            input int stall_max, input int delay_max, input int first_stall,
                            input bit spurious, input bit hold_busy, input bit expect_b2b,
                            input bit linger);
        logic [4:0]  fl;
        logic [31:0] held_addr;
        logic [31:0] rd_addr;
        int          waitc, reads, stall, delay, lat, n_exp;
        bit          hs, outst, done, busy_ok, stable_ok, holding;
        fl = 5'($urandom);
        model_build(ptbr, vpn, k0, k1, k2);
        n_exp = exp_addr.size();
        ifc.io_req_valid      = 1'b1;
        ifc.io_req_bits_addr  = vpn;
        ifc.io_req_bits_fetch = fl[0];
        ifc.io_req_bits_store = fl[1];
        ifc.io_req_bits_pum   = fl[2];
        ifc.io_req_bits_mxr   = fl[3];
        ifc.io_req_bits_prv   = {fl[4], fl[0]};
        ifc.io_ptbr_ppn       = ptbr;
        waitc = 0;
        while (!ifc.io_req_ready && waitc < 50) begin
            @(negedge clock);
            waitc++;
        end
        check_eq("req_ready", ifc.io_req_ready, 1);
        if (expect_b2b) check_eq("b2b_gap", waitc, 1);
        @(negedge clock);
        if (hold_busy) begin
            ifc.io_req_bits_addr  = 27'($urandom);
            ifc.io_req_bits_fetch = ~fl[0];
            ifc.io_req_bits_store = ~fl[1];
            ifc.io_req_bits_pum   = ~fl[2];
            ifc.io_req_bits_mxr   = ~fl[3];
            ifc.io_req_bits_prv   = ~{fl[4], fl[0]};
        end else begin
            ifc.io_req_valid = 1'b0;
        end
        ifc.io_ptbr_ppn = 20'($urandom);
        hs = 0; outst = 0; done = 0; busy_ok = 1; stable_ok = 1; holding = 0;
        reads = 0; lat = 0; delay = 0; held_addr = '0; rd_addr = '0;
        stall = (first_stall >= 0) ? first_stall : int'($urandom_range(0, stall_max));
        for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
            if (cyc > 1) @(negedge clock);
            if (hs) begin
                outst = 1;
                hs = 0;
                delay = int'($urandom_range(0, delay_max));
            end
            ifc.io_mem_resp_valid = 1'b0;
            ifc.io_mem_resp_data  = {$urandom(), $urandom()};
            if (outst) begin
                if (delay == 0) begin
                    ifc.io_mem_resp_valid = 1'b1;
                    ifc.io_mem_resp_data  = pmem.exists(rd_addr) ? pmem[rd_addr] : 64'd0;
                    outst = 0;
                end else begin
                    delay--;
                end
            end else if (spurious && $urandom_range(0, 2) == 0) begin
                ifc.io_mem_resp_valid = 1'b1;
            end
            ifc.io_mem_req_ready = 1'b0;
            if (ifc.io_mem_req_valid) begin
                if (holding && ifc.io_mem_req_addr !== held_addr) stable_ok = 0;
                if (stall == 0) begin
                    ifc.io_mem_req_ready = 1'b1;
                    hs = 1;
                    holding = 0;
                    rd_addr = ifc.io_mem_req_addr;
                    if (reads < n_exp) check_eq("rd_addr", rd_addr, exp_addr[reads]);
                    reads++;
                    stall = int'($urandom_range(0, stall_max));
                end else begin
                    holding = 1;
                    held_addr = ifc.io_mem_req_addr;
                    stall--;
                end
            end
            if (hold_busy && ifc.io_req_ready) busy_ok = 0;
            if (ifc.io_resp_valid) begin
                done = 1;
                lat = cyc;
            end
        end
        ifc.io_mem_resp_valid = 1'b0;
        ifc.io_mem_req_ready  = 1'b0;
        check_eq("resp_seen", done, 1);
        check_eq("reads", reads, n_exp);
        check_eq("addr_stable", stable_ok, 1);
        if (hold_busy) check_eq("busy_ready", busy_ok, 1);
        if (done) begin
            check_eq("pte_ppn", ifc.io_resp_pte_ppn, exp_ppn);
            check_eq("pte_bits", ifc.io_resp_pte_bits, exp_bits);
            check_eq("level", ifc.io_resp_level, exp_level);
            check_eq("fetch", ifc.io_resp_fetch, fl[0]);
            check_eq("store", ifc.io_resp_store, fl[1]);
            check_eq("pum", ifc.io_resp_pum, fl[2]);
            check_eq("mxr", ifc.io_resp_mxr, fl[3]);
            check_eq("prv", ifc.io_resp_prv, {fl[4], fl[0]});
        end
        if (stall_max == 0 && delay_max == 0 && first_stall <= 0)
            check_eq("latency", lat, 2 * n_exp + 1);
        if (linger) begin
            @(negedge clock);
            check_eq("single_pulse", ifc.io_resp_valid, 0);
            check_eq("idle_ready", ifc.io_req_ready, 1);
        end
    endtask

    task automatic reset_in_wait();
        logic [31:0] a;
        int          pulses;
        model_build(20'($urandom), 27'($urandom), 1, 4, 4);
        a = exp_addr[0];
        ifc.io_req_valid     = 1'b1;
        ifc.io_req_bits_addr = 27'($urandom);
        ifc.io_ptbr_ppn      = a[31:12];
        ifc.io_req_bits_addr[26:18] = a[11:3];
        @(negedge clock);
        ifc.io_req_valid     = 1'b0;
        check_eq("rst_in_req", ifc.io_mem_req_valid, 1);
        ifc.io_mem_req_ready = 1'b1;
        @(negedge clock);
        ifc.io_mem_req_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("rst_ready", ifc.io_req_ready, 1);
        check_eq("rst_memvalid", ifc.io_mem_req_valid, 0);
        check_eq("rst_resp", ifc.io_resp_valid, 0);
        ifc.io_mem_resp_valid = 1'b1;
        ifc.io_mem_resp_data  = pmem[a];
        @(negedge clock);
        ifc.io_mem_resp_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (ifc.io_resp_valid || ifc.io_mem_req_valid) pulses++;
            @(negedge clock);
        end
        check_eq("late_resp_dropped", pulses, 0);
        check_eq("rst_idle_ready", ifc.io_req_ready, 1);
    endtask

    initial begin
        ifc.io_req_valid      = 1'b0;
        ifc.io_req_bits_addr  = '0;
        ifc.io_req_bits_fetch = 1'b0;
        ifc.io_req_bits_store = 1'b0;
        ifc.io_req_bits_pum   = 1'b0;
        ifc.io_req_bits_mxr   = 1'b0;
        ifc.io_req_bits_prv   = '0;
        ifc.io_ptbr_ppn       = '0;
        ifc.io_mem_req_ready  = 1'b0;
        ifc.io_mem_resp_valid = 1'b0;
        ifc.io_mem_resp_data  = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_eq("reset_ready", ifc.io_req_ready, 1);
        check_eq("reset_memvalid", ifc.io_mem_req_valid, 0);
        check_eq("reset_resp", ifc.io_resp_valid, 0);
        check_eq("reset_ppn", ifc.io_resp_pte_ppn, 0);
        check_eq("reset_bits", ifc.io_resp_pte_bits, 0);
        check_eq("reset_level", ifc.io_resp_level, 0);
        check_eq("reset_flags", {ifc.io_resp_fetch, ifc.io_resp_store, ifc.io_resp_pum,
                                 ifc.io_resp_mxr, ifc.io_resp_prv}, 0);

        run_walk(20'h00010, 27'h1234567, 0, 0, 5, 0, 0, -1, 0, 0, 0, 1);
        run_walk(20'($urandom), 27'($urandom), 1, 4, 4, 0, 0, -1, 0, 0, 0, 1);
        run_walk(20'($urandom), 27'($urandom), 2, 4, 4, 0, 0, -1, 0, 0, 0, 1);
        run_walk(20'($urandom), 27'($urandom), 0, 3, 4, 0, 0, -1, 0, 0, 0, 1);
        run_walk(20'($urandom), 27'($urandom), 0, 0, 0, 0, 0, -1, 0, 0, 0, 1);
        run_walk(20'($urandom), 27'($urandom), 0, 0, 1, 2, 2, 5, 1, 0, 0, 1);
        run_walk(20'($urandom), 27'($urandom), 0, 1, 4, 1, 1, -1, 0, 1, 0, 0);
        run_walk(20'($urandom), 27'($urandom), 4, 4, 4, 0, 0, -1, 0, 0, 1, 1);
        reset_in_wait();

        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0)
                run_walk(20'($urandom), 27'($urandom), 4, 4, 4, 0, 0, -1, 0, 0, 0, 1);
            else
                run_walk(20'($urandom), 27'($urandom), 4, 4, 4, 3, 3, -1,
                         1'($urandom), 0, 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
